// File: rtl/rom_arbiter.sv
// rom_arbiter: shares the instruction ROM read port between fetch and debug.
// Fetch wins by default; a saturating wait counter bounds debug starvation.
module rom_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32,
    parameter int MAX_WAIT = 4,
    parameter logic [DATA_W-1:0] NOP_WORD = 32'h00000013
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_err,
    input  logic              dbg_req,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data
);

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_FETCH,
        OWN_DEBUG
    } owner_e;

    owner_e            owner_q;
    owner_e            owner_d;
    logic [ADDR_W-1:0] addr_q;
    logic [3:0]        wait_cnt;
    logic              if_fault;
    logic              starved;
    logic              fetch_rom;
    logic              fetch_flt;

    assign if_fault = (if_addr[1:0] != 2'b00)
                   || ((if_addr >> (ADDR_W + 2)) != 32'd0);
    assign starved  = (wait_cnt == 4'(MAX_WAIT));

    // A faulting fetch never touches the ROM, so debug can share that cycle.
    always_comb begin
        if_gnt    = 1'b0;
        dbg_gnt   = 1'b0;
        fetch_rom = 1'b0;
        fetch_flt = 1'b0;
        if (rst_n) begin
            priority case (1'b1)
                if_req && if_fault: begin
                    if_gnt    = 1'b1;
                    fetch_flt = 1'b1;
                    dbg_gnt   = dbg_req;
                end
                dbg_req && starved: begin
                    dbg_gnt = 1'b1;
                end
                if_req: begin
                    if_gnt    = 1'b1;
                    fetch_rom = 1'b1;
                end
                dbg_req: begin
                    dbg_gnt = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        owner_d = OWN_NONE;
        unique case (1'b1)
            fetch_rom: owner_d = OWN_FETCH;
            dbg_gnt:   owner_d = OWN_DEBUG;
            default:   ;
        endcase
    end

    // Idle cycles replay the last address to keep the ROM bus quiet.
    always_comb begin
        rom_addr = addr_q;
        if (fetch_rom) begin
            rom_addr = if_addr[ADDR_W+1:2];
        end else if (dbg_gnt) begin
            rom_addr = dbg_addr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q    <= OWN_NONE;
            addr_q     <= '0;
            wait_cnt   <= '0;
            if_rvalid  <= 1'b0;
            if_err     <= 1'b0;
            if_rdata   <= '0;
            dbg_rvalid <= 1'b0;
            dbg_rdata  <= '0;
        end else begin
            owner_q    <= owner_d;
            addr_q     <= rom_addr;
            if_rvalid  <= fetch_rom | fetch_flt;
            if_err     <= fetch_flt;
            dbg_rvalid <= (owner_d == OWN_DEBUG);
            if (!dbg_req || dbg_gnt) begin
                wait_cnt <= '0;
            end else if (!starved) begin
                wait_cnt <= wait_cnt + 4'd1;
            end
            if (fetch_flt) begin
                if_rdata <= NOP_WORD;
            end else if (owner_d == OWN_FETCH) begin
                if_rdata <= rom_data;
            end
            if (owner_d == OWN_DEBUG) begin
                dbg_rdata <= rom_data;
            end
        end
    end

`ifndef SYNTHESIS
    // Requesters must hold their address until granted.
    a_if_stable: assert property (@(posedge clk) disable iff (!rst_n)
        ($past(if_req && !if_gnt) && if_req) |-> $stable(if_addr));
    a_dbg_stable: assert property (@(posedge clk) disable iff (!rst_n)
        ($past(dbg_req && !dbg_gnt) && dbg_req) |-> $stable(dbg_addr));
    a_owner: assert property (@(posedge clk) disable iff (!rst_n)
        dbg_rvalid == (owner_q == OWN_DEBUG));
`endif

endmodule

// File: doc/rom_arbiter.md
Name: rom_arbiter

Overview:
- Arbitrates the single asynchronous read port of the 256x32 instruction ROM between two requesters: the core instruction fetch (byte addresses) and a debug/IO read port (word addresses).
- Registers the ROM word, so every accepted read completes with a fixed one-cycle latency.
- Fetch has priority by default. A wait counter bounds how long debug can be starved.
- Sits between the fetch stage, the debug bridge and the ROM.

Parameters:
- ADDR_W, 8, ROM word-address width (depth = 2**ADDR_W).
- DATA_W, 32, ROM word width.
- MAX_WAIT, 4, consecutive cycles debug may be refused before it is forced a grant (range 1..15).
- NOP_WORD, 32'h00000013, data returned on a faulting fetch.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request; held with if_addr stable until if_gnt.
- if_addr  in  32  fetch byte address.
- if_gnt  out  1  fetch request accepted this cycle (combinational).
- if_rvalid  out  1  fetch response valid (registered).
- if_rdata  out  DATA_W  fetch response data.
- if_err  out  1  fetch fault flag, qualified by if_rvalid.
- dbg_req  in  1  debug request; held with dbg_addr stable until dbg_gnt.
- dbg_addr  in  ADDR_W  debug word address.
- dbg_gnt  out  1  debug request accepted this cycle (combinational).
- dbg_rvalid  out  1  debug response valid (registered).
- dbg_rdata  out  DATA_W  debug response data.
- rom_addr  out  ADDR_W  ROM word address (combinational).
- rom_data  in  DATA_W  ROM read data (asynchronous).

Behaviour:
- Reset (asynchronous, rst_n=0):
  - if_rvalid, dbg_rvalid and if_err are 0.
  - if_rdata, dbg_rdata and the held address are 0.
  - The wait counter is 0 and owner = NONE.
  - if_gnt and dbg_gnt follow the combinational rules; they are 0 while rst_n=0.
- Fetch fault: if_fault = if_addr[1:0]!=0 OR if_addr[31:ADDR_W+2]!=0.
- A faulting fetch:
  - is granted immediately without using the ROM port;
  - completes next cycle with if_rvalid=1, if_err=1, if_rdata=NOP_WORD.
- Grant rules in each cycle, evaluated in order:
  1. if_req with if_fault: if_gnt=1, and debug may use the ROM the same cycle (dbg_gnt=dbg_req).
  2. dbg_req with wait counter == MAX_WAIT: dbg_gnt=1, if_gnt=0.
  3. if_req: if_gnt=1, dbg_gnt=0.
  4. dbg_req: dbg_gnt=1.
- ROM address:
  - rom_addr = if_addr[ADDR_W+1:2] on a ROM fetch grant.
  - rom_addr = dbg_addr on a debug grant.
  - Otherwise rom_addr = the held address (last granted, register), so there are no spurious ROM address toggles.
- Wait counter:
  - Increments, saturating at MAX_WAIT, each cycle with dbg_req=1 and dbg_gnt=0.
  - Clears on dbg_gnt.
  - Clears when dbg_req=0.
- Owner register (NONE/FETCH/DEBUG) is updated every edge: FETCH on a non-fault fetch grant, DEBUG on a debug grant, NONE otherwise.
- Response edge (edge after grant):
  - A ROM fetch grant sets if_rvalid=1, if_rdata=rom_data and if_err=0.
  - A debug grant sets dbg_rvalid=1 and dbg_rdata=rom_data.
  - rvalid is a 1-cycle pulse, and every response is accepted unconditionally (no backpressure).
  - rdata holds its last value when rvalid=0.
- Throughput: one ROM access per cycle. Back-to-back grants to the same requester give continuous rvalid.
- Simultaneous fault fetch and debug request: both are granted, and both rvalids assert on the same next cycle.
- A request dropped before its grant is legal and produces no response. A requester changing its address while waiting is illegal and is asserted in simulation.
- Reset mid-operation: pending responses are discarded, and no rvalid appears after rst_n deasserts unless a new grant occurs.

Test Plan:
- Fetch 0x0, 0x4, 0x8 on consecutive cycles, ROM word[1]=32'h02902283 → rom_addr=0,1,2; if_rvalid on cycles 1..3; the second response data = 32'h02902283; if_err=0.
- Fetch 0x6 → if_gnt same cycle; next cycle if_rvalid=1, if_err=1, if_rdata=32'h00000013; rom_addr unchanged.
- Fetch 0x400 (beyond 256 words) → if_err=1, if_rdata=32'h00000013.
- Continuous if_req plus dbg_req addr 5, MAX_WAIT=4 → dbg_gnt on the 5th cycle of dbg_req only, with if_gnt=0 that cycle; dbg_rvalid next cycle with dbg_rdata=ROM[5]; counter back to 0.
- Faulting fetch and dbg_req addr 3 simultaneously → both granted; next cycle if_rvalid=1 (err) and dbg_rvalid=1 with dbg_rdata=ROM[3].
- Assert rst_n=0 on the cycle after a grant → if_rvalid and dbg_rvalid forced to 0 immediately; after release no rvalid without a new request; counter 0.
